vga_sram_fetch_scheduler: RTL and testbench

- Shares the single-port external SRAM between two requesters: display prefetch feeding the VGA pixel path, and a generic writer port used by the decompression datapath.
- Display reads run ahead of the VGA scan into a small FWFT FIFO. The VGA side pops one word per displayed pixel slot.
- The writer gets every SRAM cycle the display does not urgently need.
- Sits between the VGA controller/colour unpacker and the SRAM interface.

---
 rtl/vga_sram_fetch_scheduler.sv | 153 +++++++++++++++
 tb/tb_vga_sram_fetch_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sram_fetch_scheduler.sv
// rtl/vga_sram_fetch_scheduler.sv - SRAM arbiter between VGA display prefetch FIFO and a writer port
module vga_sram_fetch_scheduler #(
    parameter logic [17:0] FRAME_BASE   = 18'd0,
    parameter logic [17:0] FRAME_WORDS  = 18'd153600,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          LOW_WATER    = 4,
    parameter int          READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iFrame_Start,
    input  logic        iPixel_Pop,
    output logic [15:0] oPixel_Data,
    output logic        oPixel_Valid,
    output logic        oUnderflow,
    input  logic        iWr_Req,
    input  logic [17:0] iWr_Address,
    input  logic [15:0] iWr_Data,
    output logic        oWr_Grant,
    output logic [17:0] oSRAM_Address,
    output logic [15:0] oSRAM_Write_Data,
    output logic        oSRAM_We_n,
    input  logic [15:0] iSRAM_Read_Data,
    output logic        oFetch_Busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = 8;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] SUM_FULL = SW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SUM_LOW  = SW'(LOW_WATER);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [17:0]           fetch_addr_q, fetch_addr_d;
    logic [17:0]           fetch_cnt_q, fetch_cnt_d;
    logic [READ_LATENCY:0] tag_q, tag_d;
    logic                  underflow_q, underflow_d;
    logic [15:0]           fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [AW:0]           occ_q;

    logic [SW-1:0] in_flight, sum;
    logic          urgent, grant, rd_issue, push, pop;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            in_flight = in_flight + SW'(tag_q[i]);
        end
        sum = SW'(occ_q) + in_flight;
    end

    // A frame restart suppresses reads that cycle but still lets a pending write through.
    always_comb begin
        urgent   = !iFrame_Start && (state_q == S_FETCH) && (sum < SUM_LOW);
        grant    = iWr_Req && !urgent;
        rd_issue = !iFrame_Start && (state_q == S_FETCH)
                   && (urgent || (!iWr_Req && (sum < SUM_FULL)));
        push     = tag_q[READ_LATENCY] && !iFrame_Start;
        pop      = iPixel_Pop && (occ_q != '0) && !iFrame_Start;
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        fetch_cnt_d  = fetch_cnt_q;
        tag_d        = {tag_q[READ_LATENCY-1:0], rd_issue};
        underflow_d  = underflow_q | (iPixel_Pop && (occ_q == '0));
        if (iFrame_Start) begin
            state_d      = S_FETCH;
            fetch_addr_d = FRAME_BASE;
            fetch_cnt_d  = '0;
            tag_d        = '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (rd_issue) begin
                        fetch_addr_d = fetch_addr_q + 18'd1;
                        fetch_cnt_d  = fetch_cnt_q + 18'd1;
                        if (fetch_cnt_q == FRAME_WORDS - 18'd1) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((in_flight == '0) && (occ_q == '0)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= '0;
            fetch_cnt_q  <= '0;
            tag_q        <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_cnt_q  <= fetch_cnt_d;
            tag_q        <= tag_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oSRAM_We_n       <= 1'b1;
            oSRAM_Address    <= '0;
            oSRAM_Write_Data <= '0;
        end else if (grant) begin
            oSRAM_We_n       <= 1'b0;
            oSRAM_Address    <= iWr_Address;
            oSRAM_Write_Data <= iWr_Data;
        end else if (rd_issue) begin
            oSRAM_We_n    <= 1'b1;
            oSRAM_Address <= fetch_addr_q;
        end else begin
            oSRAM_We_n <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= iSRAM_Read_Data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || iFrame_Start) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            assert (!(push && !pop && (occ_q == OCC_FULL)));
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign oWr_Grant    = grant;
    assign oPixel_Valid = (occ_q != '0);
    assign oPixel_Data  = oPixel_Valid ? fifo_mem_q[rd_ptr_q] : 16'd0;
    assign oUnderflow   = underflow_q;
    assign oFetch_Busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_vga_sram_fetch_scheduler.sv
// tb/tb_vga_sram_fetch_scheduler.sv - self-checking bench for vga_sram_fetch_scheduler
module tb_vga_sram_fetch_scheduler;
    localparam logic [17:0] BASE  = 18'h3FFFC;
    localparam logic [17:0] FW    = 18'd64;
    localparam int          DEPTH = 8;
    localparam int          LW    = 4;
    localparam int          RL    = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iFrame_Start = 1'b0;
    logic        iPixel_Pop = 1'b0;
    logic        iWr_Req = 1'b0;
    logic [17:0] iWr_Address = '0;
    logic [15:0] iWr_Data = '0;
    logic [15:0] iSRAM_Read_Data;
    logic [15:0] oPixel_Data;
    logic        oPixel_Valid, oUnderflow, oWr_Grant, oSRAM_We_n, oFetch_Busy;
    logic [17:0] oSRAM_Address;
    logic [15:0] oSRAM_Write_Data;

    vga_sram_fetch_scheduler #(
        .FRAME_BASE(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH),
        .LOW_WATER(LW), .READ_LATENCY(RL)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iFrame_Start(iFrame_Start), .iPixel_Pop(iPixel_Pop),
        .oPixel_Data(oPixel_Data), .oPixel_Valid(oPixel_Valid), .oUnderflow(oUnderflow),
        .iWr_Req(iWr_Req), .iWr_Address(iWr_Address), .iWr_Data(iWr_Data),
        .oWr_Grant(oWr_Grant), .oSRAM_Address(oSRAM_Address),
        .oSRAM_Write_Data(oSRAM_Write_Data), .oSRAM_We_n(oSRAM_We_n),
        .iSRAM_Read_Data(iSRAM_Read_Data), .oFetch_Busy(oFetch_Busy)
    );

    always #10 Clock = ~Clock;

    function automatic logic [15:0] mem_f(input logic [17:0] a);
        return a[15:0] ^ 16'h5A3C ^ {a[17:16], 14'd0};
    endfunction

    // SRAM: data for the address on the pins appears two cycles later
    logic [17:0] ahist0 = '0, ahist1 = '0;
    always @(posedge Clock) begin
        ahist0 <= oSRAM_Address;
        ahist1 <= ahist0;
    end
    assign iSRAM_Read_Data = mem_f(ahist1);

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {int ret; logic [17:0] a;} pend_t;

    int          m_state;
    logic [17:0] m_addr, m_cnt;
    logic [15:0] m_fifo[$];
    pend_t       m_pend[$];
    logic        m_uf, m_valid = 1'b0;
    logic        e_we;
    logic [17:0] e_addr;
    logic [15:0] e_wd;
    logic [17:0] m_reads[$];
    logic [15:0] popped[$];
    int          cyc = 0;
    int          first_valid = -1;
    int          grant_cnt = 0, lost_cnt = 0;
    int          sum, sz0, pd0;
    logic        e_grant, urgent, rd;

    always @(negedge Clock) begin
        sum = m_fifo.size() + m_pend.size();
        if (iFrame_Start) begin
            e_grant = iWr_Req;
            rd      = 1'b0;
        end else begin
            urgent  = (m_state == 1) && (sum < LW);
            e_grant = iWr_Req && !urgent;
            rd      = (m_state == 1) && (urgent || (!iWr_Req && sum < DEPTH));
        end
        if (m_valid && !Reset) begin
            check("we_n", oSRAM_We_n, e_we);
            check("sram_addr", oSRAM_Address, e_addr);
            check("sram_wdata", oSRAM_Write_Data, e_wd);
            check("pix_valid", oPixel_Valid, m_fifo.size() > 0);
            check("pix_data", oPixel_Data, (m_fifo.size() > 0) ? m_fifo[0] : 16'd0);
            check("underflow", oUnderflow, m_uf);
            check("busy", oFetch_Busy, m_state != 0);
            check("wr_grant", oWr_Grant, e_grant);
            if (iWr_Req) begin
                if (oWr_Grant) grant_cnt++;
                else lost_cnt++;
            end
            if (iPixel_Pop && oPixel_Valid && !iFrame_Start) popped.push_back(oPixel_Data);
            if (oPixel_Valid && first_valid < 0) first_valid = cyc;
        end
        if (Reset) begin
            m_state = 0; m_fifo.delete(); m_pend.delete(); m_uf = 1'b0;
            e_we = 1'b1; e_addr = '0; e_wd = '0; m_addr = '0; m_cnt = '0;
            m_valid = 1'b1;
        end else begin
            sz0 = m_fifo.size();
            pd0 = m_pend.size();
            if (iPixel_Pop && sz0 == 0) m_uf = 1'b1;
            if (iFrame_Start) begin
                m_fifo.delete(); m_pend.delete();
                m_state = 1; m_addr = BASE; m_cnt = '0;
            end else begin
                if (iPixel_Pop && sz0 > 0) void'(m_fifo.pop_front());
                if (m_pend.size() > 0 && m_pend[0].ret == cyc) begin
                    m_fifo.push_back(mem_f(m_pend[0].a));
                    void'(m_pend.pop_front());
                end
                if (m_state == 2 && pd0 == 0 && sz0 == 0) m_state = 0;
            end
            if (e_grant) begin
                e_we = 1'b0; e_addr = iWr_Address; e_wd = iWr_Data;
            end else if (rd) begin
                e_we = 1'b1; e_addr = m_addr;
                m_pend.push_back(pend_t'{cyc + 1 + RL, m_addr});
                m_reads.push_back(m_addr);
                if (m_cnt == FW - 18'd1) m_state = 2;
                m_addr = m_addr + 18'd1;
                m_cnt  = m_cnt + 18'd1;
            end else begin
                e_we = 1'b1;
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int fs_cyc;
    int n;

    initial begin
        repeat (3) next_cycle();
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_we_n", oSRAM_We_n, 1'b1);
        check("rst_addr", oSRAM_Address, 18'd0);
        check("rst_valid", oPixel_Valid, 1'b0);
        check("rst_data", oPixel_Data, 16'd0);
        check("rst_uf", oUnderflow, 1'b0);
        check("rst_busy", oFetch_Busy, 1'b0);

        // underflow is sticky across frame start, cleared by reset
        next_cycle(); iPixel_Pop = 1'b1;
        next_cycle(); iPixel_Pop = 1'b0;
        @(negedge Clock); check("uf_set", oUnderflow, 1'b1);
        next_cycle(); iFrame_Start = 1'b1;
        next_cycle(); iFrame_Start = 1'b0;
        repeat (4) next_cycle();
        @(negedge Clock); check("uf_survives_fs", oUnderflow, 1'b1);
        next_cycle(); Reset = 1'b1;
        next_cycle(); Reset = 1'b0;
        @(negedge Clock);
        check("uf_cleared", oUnderflow, 1'b0);
        check("busy_cleared", oFetch_Busy, 1'b0);

        // prefetch fills FIFO with 8 reads, wrapping past 3FFFF
        next_cycle();
        m_reads.delete(); first_valid = -1; fs_cyc = cyc; iFrame_Start = 1'b1;
        next_cycle(); iFrame_Start = 1'b0;
        repeat (20) next_cycle();
        check("fill_latency", first_valid - fs_cyc, 5);
        check("fill_reads", m_reads.size(), 8);
        check("fill_addr0", m_reads[0], 18'h3FFFC);
        check("fill_addr3", m_reads[3], 18'h3FFFF);
        check("fill_addr4", m_reads[4], 18'h00000);
        check("fill_addr7", m_reads[7], 18'h00003);
        check("fill_head", oPixel_Data, 16'h5A3C ^ 16'hFFFC ^ 16'hC000);

        // writer held high with slow pops: writes until display goes urgent
        grant_cnt = 0; lost_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            iWr_Req = 1'b1;
            iWr_Address = 18'($urandom);
            iWr_Data = 16'($urandom);
            iPixel_Pop = (i % 2 == 0) && oPixel_Valid;
            if (i == 0) begin
                @(negedge Clock); check("full_grant", oWr_Grant, 1'b1);
            end
            next_cycle();
        end
        iWr_Req = 1'b0; iPixel_Pop = 1'b0;
        check("writes_granted", grant_cnt > 0, 1'b1);
        check("urgent_read_won", lost_cnt > 0, 1'b1);
        check("no_underflow", oUnderflow, 1'b0);

        // whole frame with continuous pops and random writer traffic
        popped.delete(); iFrame_Start = 1'b1;
        next_cycle(); iFrame_Start = 1'b0;
        n = 0;
        while (n < 800 && !(n > 2 && !oFetch_Busy)) begin
            iPixel_Pop = oPixel_Valid;
            iWr_Req = 1'($urandom);
            iWr_Address = 18'($urandom);
            iWr_Data = 16'($urandom);
            next_cycle();
            n++;
        end
        iPixel_Pop = 1'b0; iWr_Req = 1'b0;
        check("frame_done_in_time", n < 800, 1'b1);
        check("frame_words", popped.size(), 64);
        for (int i = 0; i < popped.size(); i++) begin
            check("frame_word", popped[i], mem_f(BASE + 18'(i)));
        end
        @(negedge Clock); check("busy_fell", oFetch_Busy, 1'b0);

        // restart with two reads in flight: stale returns dropped
        next_cycle(); iFrame_Start = 1'b1;
        next_cycle(); iFrame_Start = 1'b0;
        next_cycle();
        next_cycle();
        check("inflight_at_restart", m_pend.size(), 2);
        m_reads.delete(); iFrame_Start = 1'b1;
        next_cycle(); iFrame_Start = 1'b0;
        @(negedge Clock); check("flush_valid", oPixel_Valid, 1'b0);
        repeat (3) next_cycle();
        @(negedge Clock); check("stale_not_pushed", oPixel_Valid, 1'b0);
        next_cycle();
        @(negedge Clock); check("restart_valid", oPixel_Valid, 1'b1);
        check("restart_addr", m_reads[0], BASE);
        check("restart_head", oPixel_Data, mem_f(BASE));

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
